// File: rtl/simple_bus_pkg.sv
// Shared types and helpers for the simple_bus multi-channel memory target.
package simple_bus_pkg;

    typedef enum logic [1:0] {
        MODE_NOP   = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_SWAP  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    // Counter/index width for n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/simple_bus_arb_mem_if.sv
// simple_bus signal bundle for N_CH requesters sharing one memory target.
interface simple_bus_arb_mem_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // A channel holds req until done; gnt is one-hot ownership. While gnt[i] is
    // high a one-cycle start[i] launches a transfer, answered by exactly one rdy[i]
    // pulse on the following cycle (rdata/err qualified by that rdy).
    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        gnt;
    logic [N_CH-1:0]        start;
    logic [N_CH*2-1:0]      mode;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH*DATA_W-1:0] wdata;
    logic [N_CH-1:0]        rdy;
    logic [DATA_W-1:0]      rdata;
    logic [N_CH-1:0]        err;
    logic [N_CH-1:0]        timeout;

    modport master (
        output req, start, mode, addr, wdata,
        input  gnt, rdy, rdata, err, timeout
    );

    modport slave (
        input  req, start, mode, addr, wdata,
        output gnt, rdy, rdata, err, timeout
    );

endinterface

// File: rtl/simple_bus_rr_arb.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module simple_bus_rr_arb
    import simple_bus_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]               req,
    input  logic [clog2_min1(N_CH)-1:0]   rr_ptr,
    output logic [N_CH-1:0]               pick,
    output logic                          any_req
);
    localparam int OW = clog2_min1(N_CH);

    logic [OW:0]   sum;
    logic [OW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = {1'b0, rr_ptr} + (OW+1)'(i);
            if (sum >= (OW+1)'(N_CH)) sum = sum - (OW+1)'(N_CH);
            idx = sum[OW-1:0];
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/simple_bus_arb_mem.sv
// Round-robin arbitrated RAM target with burst cap and out-of-range errors.
// Optional grant revocation on idle owners: define SIMPLE_BUS_TIMEOUT_EN.
module simple_bus_arb_mem
    import simple_bus_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int BURST_MAX   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    simple_bus_arb_mem_if.slave  bus,
    output arb_state_e           dbg_state
);
    localparam int OW = clog2_min1(N_CH);
    localparam int BW = clog2_min1(BURST_MAX + 1);
    localparam int MW = clog2_min1(DEPTH);

    arb_state_e        state_q, state_d;
    logic [N_CH-1:0]   gnt_q, gnt_d, rdy_q, rdy_d, err_q, err_d;
    logic [OW-1:0]     owner_q, owner_d, rr_q, rr_d, pick_idx, next_ptr;
    logic [BW-1:0]     burst_q, burst_d;
    logic [DATA_W-1:0] rdata_q;
    logic [N_CH-1:0]   pick;
    logic              any_req;

    logic              own_req, own_start, in_range, acc_fire, rd_en, wr_en;
    mode_e             own_mode;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic [MW-1:0]     mem_idx;
    logic [DATA_W-1:0] mem [DEPTH];

`ifdef SIMPLE_BUS_TIMEOUT_EN
    localparam int TW = clog2_min1(TIMEOUT_CYC);
    logic [TW-1:0]     idle_q, idle_d;
    logic [N_CH-1:0]   to_q, to_d;
`endif

    simple_bus_rr_arb #(.N_CH(N_CH)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    // Select the owner's lane and turn the one-hot pick into an index.
    always_comb begin
        own_req   = 1'b0;
        own_start = 1'b0;
        own_mode  = MODE_NOP;
        own_addr  = '0;
        own_wdata = '0;
        pick_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (owner_q == OW'(i)) begin
                own_req   = bus.req[i];
                own_start = bus.start[i];
                own_mode  = mode_e'(bus.mode[i*2 +: 2]);
                own_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
            if (pick[i]) pick_idx = OW'(i);
        end
    end

    assign next_ptr = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + 1'b1;
    assign in_range = 32'(own_addr) < 32'(DEPTH);
    assign mem_idx  = own_addr[MW-1:0];
    assign rd_en    = in_range && (own_mode == MODE_READ || own_mode == MODE_SWAP);
    assign wr_en    = in_range && (own_mode == MODE_WRITE || own_mode == MODE_SWAP);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        burst_d  = burst_q;
        rdy_d    = '0;
        err_d    = '0;
        acc_fire = 1'b0;
`ifdef SIMPLE_BUS_TIMEOUT_EN
        idle_d   = idle_q;
        to_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    burst_d = '0;
                    state_d = GRANT;
`ifdef SIMPLE_BUS_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    rr_d    = next_ptr;
                    state_d = IDLE;
                end else if (own_start) begin
                    // The RAM op happens on this edge; ACCESS is the rdy cycle.
                    acc_fire = 1'b1;
                    rdy_d    = gnt_q;
                    err_d    = in_range ? '0 : gnt_q;
                    state_d  = ACCESS;
`ifdef SIMPLE_BUS_TIMEOUT_EN
                    idle_d   = '0;
                end else if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                    gnt_d    = '0;
                    to_d     = gnt_q;
                    rr_d     = next_ptr;
                    state_d  = IDLE;
                end else begin
                    idle_d   = idle_q + 1'b1;
`endif
                end
            end
            ACCESS: begin
                burst_d = burst_q + 1'b1;
                if (burst_q + 1'b1 == BW'(BURST_MAX)) begin
                    gnt_d   = '0;
                    rr_d    = next_ptr;
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rdy_q   <= '0;
            err_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            rdata_q <= '0;
`ifdef SIMPLE_BUS_TIMEOUT_EN
            idle_q  <= '0;
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            rdata_q <= (acc_fire && rd_en) ? mem[mem_idx] : '0;
`ifdef SIMPLE_BUS_TIMEOUT_EN
            idle_q  <= idle_d;
            to_q    <= to_d;
`endif
        end
    end

    // RAM is not reset; a swap reads the old word through rdata_q above.
    always_ff @(posedge clk) begin
        if (acc_fire && wr_en) mem[mem_idx] <= own_wdata;
    end

    assign bus.gnt   = gnt_q;
    assign bus.rdy   = rdy_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
`ifdef SIMPLE_BUS_TIMEOUT_EN
    assign bus.timeout = to_q;
`else
    assign bus.timeout = '0;
`endif
    assign dbg_state = state_q;

endmodule
